instr: RTL and testbench

INSTR -- requirements
Module: instr

---
 rtl/instr.sv | 34 +++
 tb/tb_instr.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr.sv
// SPI instruction serializer: 8-bit load/shift register driving mosi from a register bit.
// Optional build macro INSTR_LSB_FIRST_EN selects LSB-first serialization (default is MSB-first).
module instr (
   input  logic       ck,
   input  logic       load_instr,
   input  logic       sh_instr,
   input  logic [7:0] reg_name,
   output logic       mosi,
   input  logic       rst_n
);

   logic [7:0] sr;
   logic [7:0] sr_shifted;

`ifdef INSTR_LSB_FIRST_EN
   assign sr_shifted = {1'b0, sr[7:1]};
   assign mosi       = sr[0];
`else
   assign sr_shifted = {sr[6:0], 1'b0};
   assign mosi       = sr[7];
`endif

   // Load has priority over shift; with neither strobe the register holds.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         sr <= 8'h00;
      end else if (load_instr) begin
         sr <= reg_name;
      end else if (sh_instr) begin
         sr <= sr_shifted;
      end
   end

endmodule

// File: tb/tb_instr.sv
// Self-checking bench for instr: directed scenarios plus randomized load/shift/reset traffic
// checked against a bit-queue model of the serial stream.
module tb_instr;

   logic       ck;
   logic       rst_n;
   logic       load_instr;
   logic       sh_instr;
   logic [7:0] reg_name;
   logic       mosi;

   int n_checks;
   int n_fail;

   // Remaining serial bits in transmit order; an empty queue means the line idles at 0.
   logic [0:0] exp_q[$];

   instr dut (
      .ck        (ck),
      .load_instr(load_instr),
      .sh_instr  (sh_instr),
      .reg_name  (reg_name),
      .mosi      (mosi),
      .rst_n     (rst_n)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: mosi=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_bit();
      return (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
   endfunction

   task automatic model_load(input logic [7:0] d);
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
`ifdef INSTR_LSB_FIRST_EN
         exp_q.push_back(d[i]);
`else
         exp_q.push_back(d[7-i]);
`endif
      end
   endtask

   task automatic step(input logic l, input logic s, input logic [7:0] d, input string tag);
      @(negedge ck);
      load_instr = l;
      sh_instr   = s;
      reg_name   = d;
      @(posedge ck);
      #1;
      if (l) model_load(d);
      else if (s && exp_q.size() > 0) void'(exp_q.pop_front());
      check(tag, mosi, exp_bit());
   endtask

   task automatic do_reset();
      @(negedge ck);
      #2;
      rst_n      = 1'b0;
      load_instr = 1'($urandom_range(0, 1));
      sh_instr   = 1'($urandom_range(0, 1));
      reg_name   = 8'($urandom);
      #1;
      exp_q.delete();
      check("async_rst", mosi, 1'b0);
      load_instr = 1'b1;
      reg_name   = 8'hFF;
      @(posedge ck);
      #1;
      check("rst_ignores_load", mosi, 1'b0);
      @(negedge ck);
      rst_n      = 1'b1;
      load_instr = 1'b0;
      sh_instr   = 1'b0;
   endtask

   logic [7:0] lit;

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      load_instr = 1'b0;
      sh_instr   = 1'b0;
      reg_name   = 8'h00;
      repeat (2) @(negedge ck);
      check("reset_mosi", mosi, 1'b0);
      rst_n = 1'b1;

      // First edge after release is honoured; shifting an empty register stays 0.
      step(0, 1, 8'h00, "shift_after_reset");

`ifndef INSTR_LSB_FIRST_EN
      lit = 8'hA5;
      step(1, 0, 8'hA5, "a5_load");
      check("a5_lit_0", mosi, lit[7]);
      for (int k = 1; k < 8; k++) begin
         step(0, 1, 8'($urandom), "a5_shift");
         check("a5_lit", mosi, lit[7-k]);
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 8'($urandom), "a5_drain");
         check("a5_lit_zero", mosi, 1'b0);
      end

      step(1, 0, 8'hFF, "ff_load");
      step(0, 1, 8'h00, "ff_shift1");
      step(0, 0, 8'h00, "ff_idle1");
      check("ff_idle1_lit", mosi, 1'b1);
      step(0, 0, 8'h3C, "ff_idle2");
      step(0, 1, 8'h00, "ff_shift2");
      check("ff_shift2_lit", mosi, 1'b1);

      step(1, 1, 8'h80, "load_wins");
      check("load_wins_lit", mosi, 1'b1);

      step(1, 0, 8'h0F, "0f_load");
      for (int k = 0; k < 3; k++) step(0, 1, 8'hFF, "0f_shift");
      check("0f_shift3_lit", mosi, 1'b0);
      step(1, 0, 8'hF0, "reload_f0");
      check("reload_f0_lit", mosi, 1'b1);
`else
      lit = 8'h0F;
      step(1, 0, 8'h0F, "lsb_load");
      check("lsb_lit_0", mosi, lit[0]);
      for (int k = 1; k < 8; k++) begin
         step(0, 1, 8'($urandom), "lsb_shift");
         check("lsb_lit", mosi, lit[k]);
      end
      step(0, 1, 8'hFF, "lsb_drain");
      check("lsb_lit_zero", mosi, 1'b0);
      step(1, 1, 8'h01, "load_wins");
      check("load_wins_lit", mosi, 1'b1);
`endif

      // Reset mid-serialization aborts; the register stays clear until the next load.
      step(1, 0, 8'hFF, "pre_rst_load");
      do_reset();
      step(0, 1, 8'h00, "post_rst_shift");
      step(0, 0, 8'hFF, "post_rst_hold");

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 65),
                 8'($urandom), "random");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
